pipe_mult: RTL and testbench
============================

Name: pipe_mult

Overview:
- Pipelined integer multiplier. It is the responder side of the multiply-unit start/done handshake.
- The mult FU wrapper drives start, sign and operands. This block returns the full 2*XLEN-bit product with a one-cycle done pulse after a fixed latency.
- It covers all RV32M multiply flavours (MUL, MULH, MULHSU, MULHU). The wrapper selects the low or high half.
- Fully pipelined: it accepts one new operation per cycle.

Parameters:
- XLEN, 32, operand width.
- NUM_STAGE, 4, pipeline depth and latency in cycles. Legal values: 1, 2, 4, 8. (2*XLEN) % NUM_STAGE == 0.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high. The wrapper ORs its refresh (squash) signal into this input.
- start  in  1  a new operation is presented this cycle.
- sign  in  2  sign[0]=1: mcand is signed; sign[1]=1: mplier is signed.
- mcand  in  XLEN  multiplicand (rs1).
- mplier  in  XLEN  multiplier (rs2).
- product  out  2*XLEN  completed product.
- done  out  1  product is valid this cycle (one pulse per accepted start).

Behaviour:
- Reset (already decided): reset reset, synchronous, active-high; clock clock.
- On reset:
  - All stage valid bits are cleared, so in-flight ops are discarded and never produce done.
  - done=0 and product=0 from the next cycle.
  - Stage operand and accumulator registers are cleared to 0.
- Operand extension at entry:
  - Each operand is extended to 2*XLEN bits: sign-extended if its sign bit is set, zero-extended otherwise.
  - The result is the low 2*XLEN bits of the extended-operand product. This is exact for signed×signed, signed×unsigned and unsigned×unsigned.
- Stage structure:
  - CHUNK = 2*XLEN/NUM_STAGE.
  - Stage i (i=0..NUM_STAGE-1) multiplies the extended mcand by mplier_ext[i*CHUNK +: CHUNK] (unsigned chunk).
  - It shifts that partial product left by i*CHUNK and adds it to the running accumulator, truncated to 2*XLEN bits.
  - It forwards the accumulator, extended mcand, remaining mplier bits and valid to the next stage register.
- Latency:
  - start sampled high at rising edge k, with operands stable in the cycle before edge k.
  - done=1 and product=result in the cycle following edge k+NUM_STAGE-1. Latency is exactly NUM_STAGE cycles.
  - NUM_STAGE=1 gives a single registered multiply.
- Throughput:
  - start may be high every cycle; no stall or backpressure exists.
  - Results emerge in issue order, one done per start, spaced exactly as the starts were.
- Idle cycles:
  - start=0 injects a bubble (valid=0). The data path may toggle, but done stays 0 for that slot.
  - product holds its last completed value while done=0. It updates only when the final stage holds a valid op.
- Operand stability: inputs are sampled only at the start edge. Changing mcand, mplier or sign afterwards does not affect an op already in flight.
- Simultaneous reset and start: reset wins. The op is not accepted and produces no done.
- done is never high for two cycles due to a single start.
- No X propagation: all registers are reset.

Test Plan:
- Unsigned: sign=00, mcand=0xFFFFFFFF, mplier=0xFFFFFFFF, start for 1 cycle -> done pulses exactly 4 cycles later for 1 cycle; product=0xFFFFFFFE_00000001. Product holds afterwards with done=0.
- Signed: sign=11, mcand=0xFFFFFFFD (-3), mplier=5 -> product=0xFFFFFFFF_FFFFFFF1. Then -1×-1 -> product=0x00000000_00000001.
- Mixed: sign=01, mcand=0xFFFFFFFF (signed -1), mplier=0xFFFFFFFF (unsigned) -> product=0xFFFFFFFF_00000001. Same operands with sign=00 -> 0xFFFFFFFE_00000001.
- Back-to-back and bubbles:
  - Input: starts on cycles 0,1,2 with 2×3, 4×5, 6×7; idle on cycle 3; start on cycle 4 with 8×9.
  - Required: done high on cycles 4,5,6 with 6, 20, 42; low on cycle 7; high on cycle 8 with 72.
- Reset mid-flight:
  - Input: start 1000×1000 on cycle 0; reset high on cycle 2 for one cycle; start 7×7 on cycle 3.
  - Required: no done for the first op; product=0 after reset; done on cycle 7 with 49.
- Reset collides with start: reset and start both high on the same cycle -> no done ever appears for that op.

Source files
------------

// File: rtl/pipe_mult.sv
// ---------------------------------------------------------------------------
// pipe_mult
//
// Pipelined integer multiplier. This block answers the multiply-unit
// start/done handshake. It returns the full 2*XLEN-bit product of two XLEN-bit
// operands exactly NUM_STAGE cycles after start. It accepts a new operation
// every cycle.
//
// Each operand is extended to 2*XLEN bits. The extension is signed or unsigned
// according to its sign bit. The low 2*XLEN bits of the extended product are
// then the exact result for MUL, MULH, MULHSU and MULHU. The wrapper picks the
// half it needs.
//
// The extended multiplier is split into NUM_STAGE chunks of CHUNK bits. Stage i
// multiplies the extended multiplicand by chunk i and adds the result into a
// running accumulator. Stage i sees the multiplicand already shifted left by
// i*CHUNK, so no stage needs a variable shifter. The multiplier register also
// drops its consumed chunk at every stage, so each stage always reads its
// chunk from the low bits.
//
// Parameters:
//   XLEN      - operand width
//   NUM_STAGE - pipeline depth and latency (1, 2, 4 or 8); must divide 2*XLEN
//
// Ports:
//   clock   in   system clock
//   reset   in   synchronous, active-high; also used by the wrapper as squash
//   start   in   a new operation is presented this cycle
//   sign    in   [0]: mcand is signed, [1]: mplier is signed
//   mcand   in   multiplicand (rs1)
//   mplier  in   multiplier (rs2)
//   product out  completed 2*XLEN-bit product (holds while done is low)
//   done    out  product is valid this cycle (one pulse per accepted start)
// ---------------------------------------------------------------------------
module pipe_mult #(
    parameter int XLEN      = 32,
    parameter int NUM_STAGE = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          sign,
    input  logic [XLEN-1:0]     mcand,
    input  logic [XLEN-1:0]     mplier,
    output logic [2*XLEN-1:0]   product,
    output logic                done
);

    localparam int PW    = 2 * XLEN;
    localparam int CHUNK = PW / NUM_STAGE;

    logic [PW-1:0] mcand_ext;
    logic [PW-1:0] mplier_ext;

    // Extend both operands to full product width. The extension is a sign
    // extension only when the operand's sign bit is set. This makes one
    // unsigned 2*XLEN multiply serve every signedness combination.
    always_comb begin
        mcand_ext  = {{XLEN{sign[0] & mcand[XLEN-1]}}, mcand};
        mplier_ext = {{XLEN{sign[1] & mplier[XLEN-1]}}, mplier};
    end

    for (genvar i = 0; i < NUM_STAGE; i++) begin : g_stage

        // Number of multiplier bits that are still unconsumed when this stage
        // takes its input.
        localparam int REM = PW - i * CHUNK;

        logic [PW-1:0]  acc_in;
        logic [PW-1:0]  mc_in;
        logic [REM-1:0] mp_in;
        logic           v_in;
        logic [PW-1:0]  pp;
        logic [PW-1:0]  acc_nx;
        logic [PW-1:0]  acc_q;
        logic           v_q;

        // Stage 0 takes its operands straight from the ports. Its accumulator
        // starts at zero. Later stages read the registers of the stage before.
        if (i == 0) begin : g_src
            assign acc_in = '0;
            assign mc_in  = mcand_ext;
            assign mp_in  = mplier_ext;
            assign v_in   = start;
        end else begin : g_src
            assign acc_in = g_stage[i-1].acc_q;
            assign mc_in  = g_stage[i-1].g_fwd.mc_q;
            assign mp_in  = g_stage[i-1].g_fwd.mp_q;
            assign v_in   = g_stage[i-1].v_q;
        end

        // The multiplicand reaching this stage is already aligned to chunk i.
        // Multiplying it by the unsigned low chunk and truncating to PW bits
        // therefore gives this stage's shifted partial product directly.
        assign pp     = mc_in * PW'(mp_in[CHUNK-1:0]);
        assign acc_nx = acc_in + pp;

        if (i < NUM_STAGE - 1) begin : g_fwd
            logic [PW-1:0]        mc_q;
            logic [REM-CHUNK-1:0] mp_q;

            // Intermediate pipeline register. The data fields load every cycle,
            // so bubbles can carry garbage. Only v_q decides whether the slot
            // counts. Reset clears everything, which discards in-flight ops.
            always_ff @(posedge clock) begin
                if (reset) begin
                    acc_q <= '0;
                    mc_q  <= '0;
                    mp_q  <= '0;
                    v_q   <= 1'b0;
                end else begin
                    acc_q <= acc_nx;
                    mc_q  <= mc_in << CHUNK;
                    mp_q  <= mp_in[REM-1:CHUNK];
                    v_q   <= v_in;
                end
            end
        end else begin : g_last
            // Final stage register. It drives the outputs directly. The
            // accumulator loads only when a valid op completes, so product
            // holds its last result through bubbles. v_q is the done pulse.
            always_ff @(posedge clock) begin
                if (reset) begin
                    acc_q <= '0;
                    v_q   <= 1'b0;
                end else begin
                    v_q <= v_in;
                    if (v_in) begin
                        acc_q <= acc_nx;
                    end
                end
            end
        end
    end

    assign product = g_stage[NUM_STAGE-1].acc_q;
    assign done    = g_stage[NUM_STAGE-1].v_q;

endmodule

// File: tb/tb_pipe_mult.sv
// ---------------------------------------------------------------------------
// tb_pipe_mult
//
// Directed testbench for pipe_mult with the default XLEN=32, NUM_STAGE=4.
// Each task covers one feature and compares DUT outputs against hand-computed
// products and done timing.
// ---------------------------------------------------------------------------
module tb_pipe_mult;

    localparam int XLEN      = 32;
    localparam int NUM_STAGE = 4;

    logic                clock;
    logic                reset;
    logic                start;
    logic [1:0]          sign;
    logic [XLEN-1:0]     mcand;
    logic [XLEN-1:0]     mplier;
    logic [2*XLEN-1:0]   product;
    logic                done;

    int n_checks;
    int n_fail;

    pipe_mult #(
        .XLEN      (XLEN),
        .NUM_STAGE (NUM_STAGE)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .sign    (sign),
        .mcand   (mcand),
        .mplier  (mplier),
        .product (product),
        .done    (done)
    );

    // Free-running clock, 10 time units per period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock. Inputs are driven and outputs sampled 1 unit after
    // the rising edge, well away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one operation for one cycle, then scramble the inputs while it is
    // in flight. Report when and how often done fired, the product seen on
    // done, and the product a few cycles afterwards.
    task automatic run_op(input logic [1:0] s, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, output int first_done,
                          output int n_done, output logic [2*XLEN-1:0] prod_seen,
                          output logic [2*XLEN-1:0] prod_after);
        first_done = -1;
        n_done     = 0;
        prod_seen  = '0;
        sign   = s;
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        sign   = ~s;
        mcand  = ~a;
        mplier = a ^ b ^ 32'h5A5A_A5A5;
        for (int c = 1; c <= 7; c++) begin
            if (done === 1'b1) begin
                if (first_done < 0) first_done = c;
                n_done++;
                prod_seen = product;
            end
            tick();
        end
        prod_after = product;
    endtask

    // Reset clears done and product.
    task automatic test_reset();
        reset  = 1'b1;
        start  = 1'b0;
        sign   = 2'b00;
        mcand  = '0;
        mplier = '0;
        tick();
        tick();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_done: got %b expected 0", done);
        end
        n_checks++;
        if (product !== 64'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_product: got %h expected 0", product);
        end
        reset = 1'b0;
        tick();
    endtask

    // Unsigned max times max. Checks latency, the single done pulse and hold.
    task automatic test_unsigned();
        int fd, nd;
        logic [63:0] ps, pa;
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, fd, nd, ps, pa);
        n_checks++;
        if (fd !== NUM_STAGE) begin
            n_fail++;
            $display("[TB] FAIL unsigned_latency: got %0d expected %0d", fd, NUM_STAGE);
        end
        n_checks++;
        if (nd !== 1) begin
            n_fail++;
            $display("[TB] FAIL unsigned_done_count: got %0d expected 1", nd);
        end
        n_checks++;
        if (ps !== 64'hFFFF_FFFE_0000_0001) begin
            n_fail++;
            $display("[TB] FAIL unsigned_product: got %h expected fffffffe00000001", ps);
        end
        n_checks++;
        if (pa !== 64'hFFFF_FFFE_0000_0001) begin
            n_fail++;
            $display("[TB] FAIL unsigned_hold: got %h expected fffffffe00000001", pa);
        end
    endtask

    // Signed times signed: -3*5, -1*-1 and most-negative squared.
    task automatic test_signed();
        int fd, nd;
        logic [63:0] ps, pa;
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [63:0] ve [3];
        va = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
        vb = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h8000_0000};
        ve = '{64'hFFFF_FFFF_FFFF_FFF1, 64'h0000_0000_0000_0001, 64'h4000_0000_0000_0000};
        for (int k = 0; k < 3; k++) begin
            run_op(2'b11, va[k], vb[k], fd, nd, ps, pa);
            n_checks++;
            if (fd !== NUM_STAGE || nd !== 1) begin
                n_fail++;
                $display("[TB] FAIL signed_done_%0d: got cycle %0d count %0d expected cycle %0d count 1",
                         k, fd, nd, NUM_STAGE);
            end
            n_checks++;
            if (ps !== ve[k]) begin
                n_fail++;
                $display("[TB] FAIL signed_product_%0d: got %h expected %h", k, ps, ve[k]);
            end
        end
    endtask

    // Mixed signedness, including the same operands read as unsigned.
    task automatic test_mixed();
        int fd, nd;
        logic [63:0] ps, pa;
        logic [1:0]  vs [3];
        logic [31:0] va [3];
        logic [31:0] vb [3];
        logic [63:0] ve [3];
        vs = '{2'b01, 2'b00, 2'b10};
        va = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0005};
        vb = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        ve = '{64'hFFFF_FFFF_0000_0001, 64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFF1};
        for (int k = 0; k < 3; k++) begin
            run_op(vs[k], va[k], vb[k], fd, nd, ps, pa);
            n_checks++;
            if (nd !== 1) begin
                n_fail++;
                $display("[TB] FAIL mixed_done_%0d: got count %0d expected 1", k, nd);
            end
            n_checks++;
            if (ps !== ve[k]) begin
                n_fail++;
                $display("[TB] FAIL mixed_product_%0d: got %h expected %h", k, ps, ve[k]);
            end
        end
    endtask

    // Starts on cycles 0,1,2 and 4 with a bubble on cycle 3. Results must
    // keep the same spacing and order.
    task automatic test_back_to_back();
        logic [31:0] ta [5];
        logic [31:0] tb [5];
        logic        tv [5];
        logic        exp_done;
        logic [63:0] exp_prod;
        int          obs;
        ta = '{32'd2, 32'd4, 32'd6, 32'd0, 32'd8};
        tb = '{32'd3, 32'd5, 32'd7, 32'd0, 32'd9};
        tv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        sign = 2'b00;
        for (int c = 0; c <= 10; c++) begin
            start  = (c < 5) ? tv[c] : 1'b0;
            mcand  = (c < 5) ? ta[c] : 32'hDEAD_BEEF;
            mplier = (c < 5) ? tb[c] : 32'h1234_5678;
            tick();
            obs = c + 1;
            exp_done = (obs == 4 || obs == 5 || obs == 6 || obs == 8);
            case (obs)
                4:       exp_prod = 64'd6;
                5:       exp_prod = 64'd20;
                6, 7:    exp_prod = 64'd42;
                default: exp_prod = 64'd72;
            endcase
            n_checks++;
            if (done !== exp_done) begin
                n_fail++;
                $display("[TB] FAIL b2b_done_c%0d: got %b expected %b", obs, done, exp_done);
            end
            if (obs >= 4) begin
                n_checks++;
                if (product !== exp_prod) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_product_c%0d: got %0d expected %0d", obs, product, exp_prod);
                end
            end
        end
        start = 1'b0;
    endtask

    // Reset on cycle 2 squashes the op started on cycle 0. The op started on
    // cycle 3 completes normally on cycle 7.
    task automatic test_reset_mid_flight();
        int obs;
        sign = 2'b00;
        for (int c = 0; c <= 9; c++) begin
            start  = (c == 0 || c == 3);
            reset  = (c == 2);
            mcand  = (c == 0) ? 32'd1000 : 32'd7;
            mplier = (c == 0) ? 32'd1000 : 32'd7;
            tick();
            obs = c + 1;
            if (obs >= 3) begin
                n_checks++;
                if (done !== (obs == 7)) begin
                    n_fail++;
                    $display("[TB] FAIL midreset_done_c%0d: got %b expected %b", obs, done, (obs == 7));
                end
                n_checks++;
                if (product !== ((obs >= 7) ? 64'd49 : 64'd0)) begin
                    n_fail++;
                    $display("[TB] FAIL midreset_product_c%0d: got %0d expected %0d",
                             obs, product, ((obs >= 7) ? 49 : 0));
                end
            end
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    // Reset and start together: that op is dropped. A start on the very next
    // cycle must still be accepted.
    task automatic test_collision();
        int obs;
        sign = 2'b00;
        for (int c = 0; c <= 7; c++) begin
            reset  = (c == 0);
            start  = (c == 0 || c == 1);
            mcand  = (c == 0) ? 32'd3 : 32'd2;
            mplier = (c == 0) ? 32'd3 : 32'd2;
            tick();
            obs = c + 1;
            n_checks++;
            if (done !== (obs == 5)) begin
                n_fail++;
                $display("[TB] FAIL collide_done_c%0d: got %b expected %b", obs, done, (obs == 5));
            end
        end
        n_checks++;
        if (product !== 64'd4) begin
            n_fail++;
            $display("[TB] FAIL collide_product: got %0d expected 4", product);
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    // Run every scenario in order, then print the summary.
    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_unsigned();
        test_signed();
        test_mixed();
        test_back_to_back();
        test_reset_mid_flight();
        test_collision();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
